// File: rtl/avalon_sram_responder.sv
// Avalon-MM pipelined-read SRAM slave: 16-bit words, byte-lane writes, fixed read latency.
// Zero-fills the whole array after reset before it accepts any traffic.
module avalon_sram_responder #(
  parameter int DEPTH        = 50000,
  parameter int READ_LATENCY = 3,
  parameter int MAX_PEND     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chipselect,
  input  logic               read_n,
  input  logic               write_n,
  input  logic [31:0]        address,
  input  logic [1:0]         byteenable,
  input  logic [15:0]        writedata,
  input  logic               stall_req,
  output logic               waitrequest,
  output logic signed [15:0] readdata,
  output logic               readdatavalid,
  output logic               init_done,
  output logic               proto_err
);

  localparam int DATA_W = 16;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW     = $clog2(MAX_PEND + 1);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                    r_state;
  logic [AW-1:0]           r_init_ptr;
  logic [PW-1:0]           r_pend;
  logic [READ_LATENCY-1:0] r_vld_pipe;
  logic [DATA_W-1:0]       r_dat_pipe [READ_LATENCY];
  logic [DATA_W-1:0]       r_mem      [DEPTH];

  logic              w_in_range;
  logic [AW-1:0]     w_addr;
  logic              w_req;
  logic              w_acc;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_err;
  logic              w_ret;
  logic [DATA_W-1:0] w_rd_data;

  assign w_in_range  = (address < 32'(DEPTH));
  assign w_addr      = address[AW-1:0];
  assign waitrequest = (r_state == ST_INIT) | stall_req | (r_pend == PW'(MAX_PEND));
  assign w_req       = chipselect & (~read_n | ~write_n);
  assign w_acc       = w_req & ~waitrequest;
  assign w_rd_acc    = w_acc & ~read_n;
  // A simultaneous read+write keeps the read and drops the write.
  assign w_wr_acc    = w_acc & ~write_n & read_n & w_in_range;
  assign w_err       = w_acc & (~w_in_range | (~read_n & ~write_n));
  assign w_ret       = r_vld_pipe[READ_LATENCY-1];
  assign w_rd_data   = w_in_range ? r_mem[w_addr] : '0;
  assign init_done   = (r_state == ST_RUN);

  // RAM write port: zero-fill during INIT, byte-lane writes afterwards
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_init_ptr] <= '0;
    end else if (w_wr_acc) begin
      if (byteenable[0]) r_mem[w_addr][7:0]  <= writedata[7:0];
      if (byteenable[1]) r_mem[w_addr][15:8] <= writedata[15:8];
    end
  end

  // Read data pipe: stage 0 captures the word at the accept edge
  always_ff @(posedge clk) begin
    r_dat_pipe[0] <= w_rd_data;
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_dat_pipe[i] <= r_dat_pipe[i-1];
    end
  end

  // Control: FSM, valid pipe, pending count, output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_INIT;
      r_init_ptr    <= '0;
      r_pend        <= '0;
      r_vld_pipe    <= '0;
      readdatavalid <= 1'b0;
      readdata      <= '0;
      proto_err     <= 1'b0;
    end else begin
      if (r_state == ST_INIT) begin
        r_init_ptr <= r_init_ptr + AW'(1);
        if (r_init_ptr == AW'(DEPTH - 1)) r_state <= ST_RUN;
      end

      r_vld_pipe[0] <= w_rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
      end

      readdatavalid <= w_ret;
      if (w_ret) readdata <= $signed(r_dat_pipe[READ_LATENCY-1]);
      proto_err <= w_err;

      case ({w_rd_acc, w_ret})
        2'b10:   r_pend <= r_pend + PW'(1);
        2'b01:   r_pend <= r_pend - PW'(1);
        default: r_pend <= r_pend;
      endcase
    end
  end

endmodule
